// File: rtl/button_debounce_handshake_if.sv
// Press-token handshake bundle between the button conditioner and its consumer.
// The master drives valid/pressed; the slave drives ready.
interface button_debounce_handshake_if;
    logic valid;
    logic ready;
    logic pressed;

    modport master (
        output valid,
        output pressed,
        input  ready
    );

    modport slave (
        input  valid,
        input  pressed,
        output ready
    );
endinterface

// File: rtl/button_debounce_handshake.sv
// Push-button synchroniser, debouncer and single-token valid/ready press source.
// Optional auto-repeat while held: define BUTTON_HANDSHAKE_REPEAT_EN.
module button_debounce_handshake #(
    parameter int unsigned DEBOUNCE_CYCLES = 742500,
    parameter logic        BUTTON_ACTIVE   = 1'b0
`ifdef BUTTON_HANDSHAKE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 37125000,
    parameter int unsigned REPEAT_PERIOD   = 7425000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    button_debounce_handshake_if.master cmd
);

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic        pin_pressed;
    logic        sync1;
    logic        sync2;
    logic        stable;
    logic [23:0] cnt;
    logic        valid;
    logic        flip;
    logic        rise;
    logic        evt;

    assign pin_pressed = ~(button ^ BUTTON_ACTIVE);
    assign flip        = (sync2 != stable) && (cnt == DB_LAST);
    assign rise        = flip && !stable;

`ifdef BUTTON_HANDSHAKE_REPEAT_EN
    localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rcnt;
    logic        first;
    logic        rpt;

    // First repeat waits the long delay, later ones the short period
    assign rpt = stable && (rcnt == (first ? RD_LAST : RP_LAST));
    assign evt = rise | rpt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt  <= '0;
            first <= 1'b1;
        end else if (!stable) begin
            rcnt  <= '0;
            first <= 1'b1;
        end else if (rpt) begin
            rcnt  <= '0;
            first <= 1'b0;
        end else begin
            rcnt  <= rcnt + 32'd1;
        end
    end
`else
    assign evt = rise;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            valid  <= 1'b0;
        end else begin
            sync1 <= pin_pressed;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 24'd1;
            end
            // A new event wins over a same-edge accept; no queueing
            valid <= evt | (valid & ~cmd.ready);
        end
    end

    assign cmd.valid   = valid;
    assign cmd.pressed = stable;

endmodule

// File: tb/tb_button_debounce_handshake.sv
// Randomised bench for button_debounce_handshake with a window-based model.
// Define BUTTON_HANDSHAKE_REPEAT_EN to also cover auto-repeat.
module tb_button_debounce_handshake;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button = 1'b1;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    button_debounce_handshake_if bus ();

    button_debounce_handshake #(
        .DEBOUNCE_CYCLES(D),
        .BUTTON_ACTIVE  (1'b0)
`ifdef BUTTON_HANDSHAKE_REPEAT_EN
        ,
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .button(button),
        .cmd   (bus)
    );

    always #5 clk = ~clk;

    // Model: pin samples since reset; stable flips once the last D
    // synchronised samples all disagree with it.
    bit q[$];
    bit m_stable = 1'b0;
    bit m_valid = 1'b0;
    int since = 0;

    always @(posedge clk or posedge reset) begin
        bit ev;
        bit fl;
        int e;
        if (reset) begin
            q.delete();
            m_stable = 1'b0;
            m_valid  = 1'b0;
            since    = 0;
        end else begin
            cycle++;
            q.push_back(button == 1'b0);
            e  = q.size() - 1;
            fl = 1'b0;
            if (e >= D + 1) begin
                fl = 1'b1;
                for (int k = e - D - 1; k <= e - 2; k++)
                    if (q[k] == m_stable) fl = 1'b0;
            end
            ev = fl && !m_stable;
`ifdef BUTTON_HANDSHAKE_REPEAT_EN
            if (m_stable) begin
                since++;
                if (since == RD ||
                    (since > RD && (since - RD) % RP == 0))
                    ev = 1'b1;
            end else begin
                since = 0;
            end
`endif
            m_valid = ev | (m_valid & !bus.ready);
            if (fl) m_stable = !m_stable;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            compared++;
            if (bus.valid !== m_valid || bus.pressed !== m_stable) begin
                mismatched++;
                $display("FAIL model cyc=%0d valid=%b/%b pressed=%b/%b",
                         cycle, bus.valid, m_valid,
                         bus.pressed, m_stable);
            end
        end
    end

    task automatic chk(input string name, input logic act,
                       input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic press_and_pin();
        button = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("lat_valid_e4", bus.valid, 1'b0);
        chk("lat_press_e4", bus.pressed, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid_e5", bus.valid, 1'b1);
        chk("lat_press_e5", bus.pressed, 1'b1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.ready = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_pressed", bus.pressed, 1'b0);

        // Released pin
        cyc(20);
        chk("idle_valid", bus.valid, 1'b0);
        chk("idle_pressed", bus.pressed, 1'b0);

        // Press, pinned latency, held without ready
        press_and_pin();
        cyc(50);
        chk("hold_valid", bus.valid, 1'b1);

        // One-cycle accept
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_valid", bus.valid, 1'b0);
        @(negedge clk);
        #1;
        bus.ready = 1'b0;
        cyc(20);
`ifndef BUTTON_HANDSHAKE_REPEAT_EN
        chk("no_retoken", bus.valid, 1'b0);
`endif
        button = 1'b1;
        cyc(15);
        chk("release_pressed", bus.pressed, 1'b0);
        bus.ready = 1'b1;
        cyc(2);
        bus.ready = 1'b0;

        // Short glitch
        button = 1'b0;
        cyc(3);
        button = 1'b1;
        cyc(12);
        chk("glitch_valid", bus.valid, 1'b0);
        chk("glitch_pressed", bus.pressed, 1'b0);

        // Second press while token pending
        button = 1'b0;
        cyc(10);
        button = 1'b1;
        cyc(10);
        button = 1'b0;
        cyc(10);
        chk("drop_valid", bus.valid, 1'b1);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_accept", bus.valid, 1'b0);
        @(negedge clk);
        #1;
        bus.ready = 1'b0;
        button = 1'b1;
        cyc(15);

        // Reset with token pending and pin held through release
        button = 1'b0;
        cyc(10);
        do_reset();
        chk("midrst_valid", bus.valid, 1'b0);
        press_and_pin();
        button = 1'b1;
        bus.ready = 1'b1;
        cyc(15);
        bus.ready = 1'b0;

`ifdef BUTTON_HANDSHAKE_REPEAT_EN
        begin
            int pulses = 0;
            bus.ready = 1'b1;
            button = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                if (bus.valid) pulses++;
                if (i == 36) button = 1'b1;
            end
            compared++;
            if (pulses != 3) begin
                mismatched++;
                $display("FAIL repeat_pulses got=%0d want=3", pulses);
            end
            @(negedge clk);
            #1;
            bus.ready = 1'b0;
        end
`endif

        // Random bouncing pin and random ready
        for (int r = 0; r < 300; r++) begin
            int len;
            len = $urandom_range(1, 12);
            button = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0) do_reset();
            for (int c = 0; c < len; c++) begin
                bus.ready = ($urandom_range(0, 2) == 0);
                cyc(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
